// File: rtl/jk_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_seq_pkg
// Description : Shared definitions for the JK command sequencer.
//               - OP_* : {j,k} command encodings
//               - state_t : sequencer FSM states
//               - jk_next : JK flip-flop next-state function for the q model
// Revision    : 1.0 - initial release
// ============================================================================
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            OP_HOLD:   r = q;
            OP_RESET:  r = 1'b0;
            OP_SET:    r = 1'b1;
            default:   r = ~q;
        endcase
        return r;
    endfunction

endpackage : jk_seq_pkg
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_fifo
// Description : Synchronous command FIFO with flush.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   i_push   in   write i_wdata (ignored when full)
//   i_pop    in   drop head entry (ignored when empty)
//   i_flush  in   empty the FIFO
//   i_wdata  in   WIDTH-bit entry
//   o_rdata  out  head entry (valid when !o_empty)
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
//   o_count  out  entries held
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // Full blocks a push even if the head is popped the same edge.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule : jk_cmd_fifo
`default_nettype wire

// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_sequencer
// Description : Drives j/k of a JK flip-flop from a queued command stream
//               and checks the returned q against a reference model.
//   clk         in   clock
//   clr         in   synchronous active-high reset
//   cmd_valid   in   command offered
//   cmd_ready   out  FIFO not full
//   cmd_op      in   {j,k}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_len     in   edges to apply (0 means 1)
//   flush       in   abort: empty FIFO, return to IDLE
//   j, k        out  flip-flop inputs
//   q_in        in   flip-flop q
//   exp_q       out  modelled q
//   mismatch    out  sticky q_in != exp_q
//   done        out  pulse after a command's last edge
//   busy        out  applying a command
//   fifo_count  out  queued commands
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_len,
    input  logic                     flush,
    output logic                     j,
    output logic                     k,
    input  logic                     q_in,
    output logic                     exp_q,
    output logic                     mismatch,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    import jk_seq_pkg::*;

    localparam int c_DW = 2 + CNT_W;

    logic              w_push, w_pop, w_full, w_empty;
    logic [c_DW-1:0]   w_wdata, w_head;
    logic [1:0]        w_head_op;
    logic [CNT_W-1:0]  w_head_len, w_head_cnt;

    state_t            r_state, w_state_nxt;
    logic              r_j, r_k, w_j_nxt, w_k_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_exp_q, w_exp_q_nxt;
    logic              r_mismatch, w_mismatch_nxt;
    logic              r_done, w_done_nxt;
    logic              r_chk_en;

    assign cmd_ready  = !w_full;
    assign w_push     = cmd_valid && !w_full && !flush;
    assign w_wdata    = {cmd_op, cmd_len};
    assign w_head_op  = w_head[c_DW-1 -: 2];
    assign w_head_len = w_head[CNT_W-1:0];
    assign w_head_cnt = (w_head_len == '0) ? CNT_W'(1) : w_head_len;

    assign j          = r_j;
    assign k          = r_k;
    assign exp_q      = r_exp_q;
    assign mismatch   = r_mismatch;
    assign done       = r_done;
    assign busy       = (r_state == APPLY);

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_cnt      <= '0;
            r_exp_q    <= 1'b0;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
            r_chk_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_cnt      <= w_cnt_nxt;
            r_exp_q    <= w_exp_q_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_done     <= w_done_nxt;
            r_chk_en   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_j_nxt        = r_j;
        w_k_nxt        = r_k;
        w_cnt_nxt      = r_cnt;
        w_exp_q_nxt    = r_exp_q;
        w_done_nxt     = 1'b0;
        w_pop          = 1'b0;
        // The first edge after clr is skipped: the flip-flop is only just
        // leaving its own clear.
        w_mismatch_nxt = r_mismatch | (r_chk_en & (q_in != r_exp_q));

        if (flush) begin
            w_state_nxt = IDLE;
            w_j_nxt     = 1'b0;
            w_k_nxt     = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_j_nxt     = w_head_op[1];
                        w_k_nxt     = w_head_op[0];
                        w_cnt_nxt   = w_head_cnt;
                        w_state_nxt = APPLY;
                    end else begin
                        w_j_nxt = 1'b0;
                        w_k_nxt = 1'b0;
                    end
                end
                APPLY: begin
                    w_exp_q_nxt = jk_next(r_exp_q, r_j, r_k);
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_done_nxt = 1'b1;
                        // Chain straight into the next command with no gap.
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_j_nxt   = w_head_op[1];
                            w_k_nxt   = w_head_op[0];
                            w_cnt_nxt = w_head_cnt;
                        end else begin
                            w_state_nxt = IDLE;
                            w_j_nxt     = 1'b0;
                            w_k_nxt     = 1'b0;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_j_nxt     = 1'b0;
                    w_k_nxt     = 1'b0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule : jk_cmd_sequencer
`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_cmd_sequencer
// Description : Directed self-checking bench for jk_cmd_sequencer. A
//               behavioural JK flip-flop closes the q loop; inj inverts the
//               returned q to provoke a mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_sequencer;

    logic       clk;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       flush;
    logic       j;
    logic       k;
    logic       q_in;
    logic       exp_q;
    logic       mismatch;
    logic       done;
    logic       busy;
    logic [2:0] fifo_count;

    logic       ff_q;
    logic       inj;
    int         checks;
    int         failures;

    jk_cmd_sequencer #(
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .flush      (flush),
        .j          (j),
        .k          (k),
        .q_in       (q_in),
        .exp_q      (exp_q),
        .mismatch   (mismatch),
        .done       (done),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flip-flop under control; it shares clr and, here, the flush abort.
    always @(posedge clk) begin
        if (clr) begin
            ff_q <= 1'b0;
        end else if (!flush) begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_in = ff_q ^ inj;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 4'd0;
        flush     = 1'b0;
        inj       = 1'b0;

        // ---- reset ----
        tick();
        tick();
        chk("rst_j",        32'(j),          0);
        chk("rst_k",        32'(k),          0);
        chk("rst_exp_q",    32'(exp_q),      0);
        chk("rst_ready",    32'(cmd_ready),  1);
        chk("rst_count",    32'(fifo_count), 0);
        chk("rst_mismatch", 32'(mismatch),   0);
        chk("rst_done",     32'(done),       0);
        chk("rst_busy",     32'(busy),       0);

        // ---- SET len=3 into idle block ----
        clr = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        chk("set_push_count", 32'(fifo_count), 1);
        chk("set_push_j",     32'(j),          0);
        tick();
        chk("set_e0_j",     32'(j),          1);
        chk("set_e0_k",     32'(k),          0);
        chk("set_e0_busy",  32'(busy),       1);
        chk("set_e0_count", 32'(fifo_count), 0);
        chk("set_e0_exp",   32'(exp_q),      0);
        tick();
        chk("set_e1_j",    32'(j),     1);
        chk("set_e1_exp",  32'(exp_q), 1);
        chk("set_e1_done", 32'(done),  0);
        tick();
        chk("set_e2_j",    32'(j),     1);
        chk("set_e2_done", 32'(done),  0);
        tick();
        chk("set_e3_j",    32'(j),     0);
        chk("set_e3_k",    32'(k),     0);
        chk("set_e3_done", 32'(done),  1);
        chk("set_e3_busy", 32'(busy),  0);
        chk("set_e3_exp",  32'(exp_q), 1);
        tick();
        chk("set_e4_done",     32'(done),     0);
        chk("set_e4_exp",      32'(exp_q),    1);
        chk("set_e4_mismatch", 32'(mismatch), 0);

        // ---- TOGGLE len=4 then RESET len=0 back-to-back ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr1_exp", 32'(exp_q), 0);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd4;
        tick();
        cmd_op = 2'b01; cmd_len = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk("tg_load_j",     32'(j),          1);
        chk("tg_load_k",     32'(k),          1);
        chk("tg_load_count", 32'(fifo_count), 1);
        chk("tg_load_exp",   32'(exp_q),      0);
        tick();
        chk("tg_e1_exp", 32'(exp_q), 1);
        tick();
        chk("tg_e2_exp", 32'(exp_q), 0);
        tick();
        chk("tg_e3_exp", 32'(exp_q), 1);
        tick();
        chk("tg_e4_exp",   32'(exp_q),      0);
        chk("tg_e4_done",  32'(done),       1);
        chk("tg_e4_j",     32'(j),          0);
        chk("tg_e4_k",     32'(k),          1);
        chk("tg_e4_busy",  32'(busy),       1);
        chk("tg_e4_count", 32'(fifo_count), 0);
        tick();
        chk("rs_e1_exp",  32'(exp_q), 0);
        chk("rs_e1_done", 32'(done),  1);
        chk("rs_e1_j",    32'(j),     0);
        chk("rs_e1_k",    32'(k),     0);
        chk("rs_e1_busy", 32'(busy),  0);
        tick();
        chk("rs_e2_done",     32'(done),     0);
        chk("rs_e2_mismatch", 32'(mismatch), 0);

        // ---- fill FIFO while HOLD len=8 applies ----
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 4'd8;
        tick();
        cmd_op = 2'b10; cmd_len = 4'd2;
        tick();
        chk("fill_b2_count", 32'(fifo_count), 1);
        chk("fill_b2_busy",  32'(busy),       1);
        chk("fill_b2_j",     32'(j),          0);
        tick();
        tick();
        tick();
        chk("fill_b5_count", 32'(fifo_count), 4);
        chk("fill_b5_ready", 32'(cmd_ready),  0);
        repeat (4) tick();
        chk("fill_b9_count", 32'(fifo_count), 4);
        chk("fill_b9_ready", 32'(cmd_ready),  0);
        chk("fill_b9_busy",  32'(busy),       1);
        tick();
        chk("fill_b10_count", 32'(fifo_count), 3);
        chk("fill_b10_ready", 32'(cmd_ready),  1);
        chk("fill_b10_done",  32'(done),       1);
        chk("fill_b10_j",     32'(j),          1);
        chk("fill_b10_k",     32'(k),          0);
        tick();
        cmd_valid = 1'b0;
        chk("fill_b11_count", 32'(fifo_count), 4);
        chk("fill_b11_ready", 32'(cmd_ready),  0);
        chk("fill_b11_exp",   32'(exp_q),      1);

        // ---- flush mid-APPLY of TOGGLE len=8 ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr2_count", 32'(fifo_count), 0);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd8;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("fl_e1_exp", 32'(exp_q), 1);
        tick();
        chk("fl_e2_exp", 32'(exp_q), 0);
        tick();
        chk("fl_e3_exp",  32'(exp_q), 1);
        chk("fl_e3_busy", 32'(busy),  1);
        flush = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd1;
        tick();
        flush = 1'b0; cmd_valid = 1'b0;
        chk("fl_j",        32'(j),          0);
        chk("fl_k",        32'(k),          0);
        chk("fl_busy",     32'(busy),       0);
        chk("fl_count",    32'(fifo_count), 0);
        chk("fl_exp",      32'(exp_q),      1);
        chk("fl_done",     32'(done),       0);
        chk("fl_mismatch", 32'(mismatch),   0);
        tick();
        chk("fl_after_busy",  32'(busy),       0);
        chk("fl_after_count", 32'(fifo_count), 0);
        chk("fl_after_j",     32'(j),          0);

        // ---- mismatch injection ----
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("mm_set", 32'(mismatch), 1);
        repeat (3) tick();
        chk("mm_sticky", 32'(mismatch), 1);
        clr = 1'b1;
        tick();
        chk("mm_clr",     32'(mismatch), 0);
        chk("mm_clr_exp", 32'(exp_q),    0);
        clr = 1'b0; inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("mm_first_edge_skip", 32'(mismatch), 0);
        tick();
        chk("mm_quiet", 32'(mismatch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jk_cmd_sequencer
`default_nettype wire
